pe_load_sequencer: RTL and testbench
====================================

# pe_load_sequencer

Sequences the write phase of a PE group. It accepts a stream of data words, distributes them round-robin across the group's PEs over the packed `{pe_id, valid, namespace_id}` control bus, and waits for every PE to report end-of-compute. It then signals completion to the host-side controller. It sits between the memory/AXI read engine and the PE array, one instance per PE group.

## Interface
- `DATA_WIDTH`, 16, data word width.
- `PE_ID_WIDTH`, 2, PE id width; `NUM_PE = 2**PE_ID_WIDTH`.
- `NAMESPACE_WIDTH`, 2, namespace id width.
- `CTRL_PE_WIDTH`, `PE_ID_WIDTH+1+NAMESPACE_WIDTH`, packed control width.
- `COUNT_WIDTH`, 16, width of the words-per-PE count.
- `TIMEOUT_CYCLES`, 4096, EOC watchdog limit; only used with the macro.

Ports:
- `ACLK`  in  1  sole clock, rising edge.
- `ARESETN`  in  1  synchronous, active-low reset.
- `START`  in  1  one-cycle pulse; begins a load when idle.
- `cfg_words_per_pe`  in  COUNT_WIDTH  words per PE, sampled on accepted `START`.
- `cfg_namespace`  in  NAMESPACE_WIDTH  target namespace, sampled on accepted `START`.
- `s_data`  in  DATA_WIDTH  input word.
- `s_valid`  in  1  input word valid.
- `s_ready`  out  1  sequencer can accept a word.
- `pe_data`  out  DATA_WIDTH  registered word to the PE array.
- `pe_ctrl`  out  CTRL_PE_WIDTH  `{pe_id, valid, namespace_id}`, registered.
- `pe_eoc`  in  NUM_PE  per-PE end-of-compute level.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle completion pulse.
- `error`  out  1  sticky watchdog flag; tied 0 without the macro.

## Operation
- States: IDLE, LOAD, WAIT_EOC, DONE.
- IDLE:
  - `START` latches the config, clears the PE index, word count and EOC mask.
  - Goes to LOAD, or to DONE if `cfg_words_per_pe == 0`.
- LOAD:
  - `s_ready = 1`. Each handshake (`s_valid && s_ready`) registers `pe_data <= s_data` and `pe_ctrl <= {pe_idx, 1, ns}`.
  - `pe_idx` increments and wraps from `NUM_PE-1` to 0. On each wrap the word count increments.
  - When the word count reaches `cfg_words_per_pe` on a wrap, goes to WAIT_EOC. No further beats are accepted that cycle.
  - With no handshake, the valid bit of `pe_ctrl` is 0; the pe_id and namespace fields hold.
- EOC mask: `mask |= pe_eoc` every cycle in LOAD and WAIT_EOC, so early EOC is captured.
- WAIT_EOC: `s_ready = 0`. When `mask` is all ones, goes to DONE.
- DONE: `done = 1` for exactly one cycle, then IDLE.
- Total beats per load = `NUM_PE * cfg_words_per_pe`. Counters are unsigned and never wrap within a load.
- `START` outside IDLE is ignored. `START` in the same cycle as the DONE state is ignored.
- The `error` flag clears only on reset or on the next accepted `START`.

## Timing
- Reset values: state IDLE, `s_ready 0`, `pe_data 0`, `pe_ctrl 0`, `busy 0`, `done 0`, `error 0`, counters and mask 0.
- `START` at cycle T: `busy` and `s_ready` are high at T+1.
- Latency from handshake at T to `pe_ctrl` valid at T+1 is 1 cycle. Full throughput is one word per cycle.
- The last handshake is at T. `s_ready` is low at T+1 and WAIT_EOC is entered at T+1.
- If the mask is already full at T+1, `done` pulses at T+2.
- `ARESETN` low mid-load: returns to reset values at the next edge. Partial loads are discarded and not resumed.

## Configuration
- `PE_LOAD_TIMEOUT_EN` defined:
  - A watchdog counts cycles in WAIT_EOC.
  - When it reaches `TIMEOUT_CYCLES`, `error` is set and the FSM goes to DONE; `done` still pulses.
- Undefined: no watchdog, `error` tied 0, and WAIT_EOC waits indefinitely.

## Structure
- Shared package `pe_sched_pkg`:
  - State enum.
  - Field-position localparams for `pe_ctrl` packing (pe_id MSBs, valid, namespace LSBs).
  - Shared by the PE wrappers for unpacking.
- Sub-module `pe_eoc_tracker`:
  - Sticky OR mask with clear and an all-done output.
  - Holds the watchdog counter when `PE_LOAD_TIMEOUT_EN` is defined.

## Test plan
- Basic load: `NUM_PE=4`, `words=2`, `ns=1`, `s_valid` held high with data 0x10..0x17 → `pe_ctrl` pe_ids 0,1,2,3,0,1,2,3 with valid 1, ns 1, data in order, one cycle after each handshake. Then, with `pe_eoc = 0xF`, `done` pulses 2 cycles after the last beat.
- Backpressure gaps: `s_valid` toggling 1,0,1,0 → no valid `pe_ctrl` on gap cycles and pe_id order unchanged. `s_ready` drops exactly after beat 8.
- Staggered EOC: PE2 EOC pulses during LOAD, the others after → the mask retains PE2 and `done` fires only after the last PE's EOC.
- Zero words: `START` with `words=0` → no `s_ready`, `done` at T+2, `busy` high only at T+1.
- Reset mid-load: deassert `ARESETN` after 3 beats → all outputs zero next cycle. A new `START` restarts at pe_id 0.
- Watchdog (`PE_LOAD_TIMEOUT_EN`, `TIMEOUT_CYCLES=16`): `pe_eoc` stuck at 0x7 → `error = 1` and `done` pulses after 16 WAIT_EOC cycles. `error` clears on the next `START`.

Source files
------------

// File: rtl/pe_sched_pkg.sv
// rtl/pe_sched_pkg.sv - shared PE group sequencing types and pe_ctrl field positions
package pe_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_LOAD     = 2'd1,
        ST_WAIT_EOC = 2'd2,
        ST_DONE     = 2'd3
    } pe_load_state_e;

    // pe_ctrl packs {pe_id, valid, namespace_id}: namespace in the LSBs, pe_id in the MSBs
    localparam int CTRL_NS_LSB = 0;

    function automatic int ctrl_valid_bit(input int ns_width);
        return ns_width;
    endfunction

    function automatic int ctrl_pe_id_lsb(input int ns_width);
        return ns_width + 1;
    endfunction

endpackage

// File: rtl/pe_eoc_tracker.sv
// rtl/pe_eoc_tracker.sv - sticky end-of-compute mask; watchdog present with PE_LOAD_TIMEOUT_EN
module pe_eoc_tracker #(
    parameter int NUM_PE = 4
`ifdef PE_LOAD_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 4096
`endif
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              i_clear,
    input  logic              i_capture,
    input  logic [NUM_PE-1:0] i_eoc,
`ifdef PE_LOAD_TIMEOUT_EN
    input  logic              i_wait,
`endif
    output logic              o_all_done,
    output logic              o_timeout
);

    logic [NUM_PE-1:0] r_mask;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_mask <= '0;
        end else if (i_clear) begin
            r_mask <= '0;
        end else if (i_capture) begin
            r_mask <= r_mask | i_eoc;
        end
    end

    assign o_all_done = &r_mask;

`ifdef PE_LOAD_TIMEOUT_EN
    localparam int WD_WIDTH = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_WIDTH-1:0] r_wd;

    // Restarts from zero whenever the sequencer is not waiting on EOC
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_wd <= '0;
        end else if (i_clear || !i_wait) begin
            r_wd <= '0;
        end else begin
            r_wd <= r_wd + 1'b1;
        end
    end

    assign o_timeout = i_wait && (r_wd == WD_WIDTH'(TIMEOUT_CYCLES - 1));
`else
    assign o_timeout = 1'b0;
`endif

endmodule

// File: rtl/pe_load_sequencer.sv
// rtl/pe_load_sequencer.sv - round-robin PE group load sequencer; PE_LOAD_TIMEOUT_EN enables the EOC watchdog
module pe_load_sequencer
    import pe_sched_pkg::*;
#(
    parameter int DATA_WIDTH      = 16,
    parameter int PE_ID_WIDTH     = 2,
    parameter int NAMESPACE_WIDTH = 2,
    parameter int CTRL_PE_WIDTH   = PE_ID_WIDTH + 1 + NAMESPACE_WIDTH,
    parameter int COUNT_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES  = 4096
) (
    input  logic                        ACLK,
    input  logic                        ARESETN,
    input  logic                        START,
    input  logic [COUNT_WIDTH-1:0]      cfg_words_per_pe,
    input  logic [NAMESPACE_WIDTH-1:0]  cfg_namespace,
    input  logic [DATA_WIDTH-1:0]       s_data,
    input  logic                        s_valid,
    output logic                        s_ready,
    output logic [DATA_WIDTH-1:0]       pe_data,
    output logic [CTRL_PE_WIDTH-1:0]    pe_ctrl,
    input  logic [2**PE_ID_WIDTH-1:0]   pe_eoc,
    output logic                        busy,
    output logic                        done,
    output logic                        error
);

    localparam int NUM_PE    = 2**PE_ID_WIDTH;
    localparam int VALID_BIT = ctrl_valid_bit(NAMESPACE_WIDTH);

    pe_load_state_e              r_state, w_nxt;
    logic [COUNT_WIDTH-1:0]      r_cfg_words;
    logic [NAMESPACE_WIDTH-1:0]  r_cfg_ns;
    logic [PE_ID_WIDTH-1:0]      r_pe_idx;
    logic [COUNT_WIDTH-1:0]      r_word_cnt;
    logic [DATA_WIDTH-1:0]       r_pe_data;
    logic [CTRL_PE_WIDTH-1:0]    r_pe_ctrl;
    logic                        r_done;
    logic                        w_start_acc, w_hs, w_wrap, w_last;
    logic                        w_all_done, w_timeout;

    assign w_start_acc = START && (r_state == ST_IDLE);
    assign w_hs        = s_valid && s_ready;
    assign w_wrap      = w_hs && (r_pe_idx == PE_ID_WIDTH'(NUM_PE - 1));
    assign w_last      = w_wrap && ((r_word_cnt + 1'b1) == r_cfg_words);

    pe_eoc_tracker #(
        .NUM_PE         (NUM_PE)
`ifdef PE_LOAD_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
`endif
    ) u_eoc_tracker (
        .clk        (ACLK),
        .resetn     (ARESETN),
        .i_clear    (w_start_acc),
        .i_capture  ((r_state == ST_LOAD) || (r_state == ST_WAIT_EOC)),
        .i_eoc      (pe_eoc),
`ifdef PE_LOAD_TIMEOUT_EN
        .i_wait     (r_state == ST_WAIT_EOC),
`endif
        .o_all_done (w_all_done),
        .o_timeout  (w_timeout)
    );

    always_comb begin
        w_nxt = r_state;
        case (r_state)
            ST_IDLE:     if (w_start_acc) w_nxt = (cfg_words_per_pe == '0) ? ST_DONE : ST_LOAD;
            ST_LOAD:     if (w_last) w_nxt = ST_WAIT_EOC;
            ST_WAIT_EOC: if (w_all_done || w_timeout) w_nxt = ST_DONE;
            ST_DONE:     w_nxt = ST_IDLE;
            default:     w_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            r_state     <= ST_IDLE;
            r_cfg_words <= '0;
            r_cfg_ns    <= '0;
            r_pe_idx    <= '0;
            r_word_cnt  <= '0;
            r_pe_data   <= '0;
            r_pe_ctrl   <= '0;
            r_done      <= 1'b0;
        end else begin
            r_state <= w_nxt;
            if (w_start_acc) begin
                r_cfg_words <= cfg_words_per_pe;
                r_cfg_ns    <= cfg_namespace;
                r_pe_idx    <= '0;
                r_word_cnt  <= '0;
            end
            if (w_hs) begin
                r_pe_data <= s_data;
                r_pe_ctrl <= {r_pe_idx, 1'b1, r_cfg_ns};
                r_pe_idx  <= r_pe_idx + 1'b1;
                if (w_wrap) r_word_cnt <= r_word_cnt + 1'b1;
            end else begin
                r_pe_ctrl[VALID_BIT] <= 1'b0;
            end
            // Pulse lands with DONE when reached from WAIT_EOC, one cycle after DONE for an empty load
            r_done <= ((r_state == ST_WAIT_EOC) && (w_nxt == ST_DONE)) ||
                      ((r_state == ST_DONE) && !r_done);
        end
    end

`ifdef PE_LOAD_TIMEOUT_EN
    logic r_error;

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            r_error <= 1'b0;
        end else if (w_start_acc) begin
            r_error <= 1'b0;
        end else if (w_timeout) begin
            r_error <= 1'b1;
        end
    end

    assign error = r_error;
`else
    assign error = 1'b0;
`endif

    assign s_ready = (r_state == ST_LOAD);
    assign busy    = (r_state != ST_IDLE);
    assign done    = r_done;
    assign pe_data = r_pe_data;
    assign pe_ctrl = r_pe_ctrl;

endmodule

// File: tb/tb_pe_load_sequencer.sv
// tb/tb_pe_load_sequencer.sv - directed self-checking bench for pe_load_sequencer
module tb_pe_load_sequencer;

    logic        ACLK;
    logic        ARESETN;
    logic        START;
    logic [15:0] cfg_words_per_pe;
    logic [1:0]  cfg_namespace;
    logic [15:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] pe_data;
    logic [4:0]  pe_ctrl;
    logic [3:0]  pe_eoc;
    logic        busy;
    logic        done;
    logic        error;

    int n_checks = 0;
    int n_errors = 0;

    pe_load_sequencer #(
        .DATA_WIDTH      (16),
        .PE_ID_WIDTH     (2),
        .NAMESPACE_WIDTH (2),
        .CTRL_PE_WIDTH   (5),
        .COUNT_WIDTH     (16),
        .TIMEOUT_CYCLES  (16)
    ) dut (
        .ACLK             (ACLK),
        .ARESETN          (ARESETN),
        .START            (START),
        .cfg_words_per_pe (cfg_words_per_pe),
        .cfg_namespace    (cfg_namespace),
        .s_data           (s_data),
        .s_valid          (s_valid),
        .s_ready          (s_ready),
        .pe_data          (pe_data),
        .pe_ctrl          (pe_ctrl),
        .pe_eoc           (pe_eoc),
        .busy             (busy),
        .done             (done),
        .error            (error)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    task automatic do_reset();
        ARESETN          = 1'b0;
        START            = 1'b0;
        s_valid          = 1'b0;
        s_data           = '0;
        pe_eoc           = '0;
        cfg_words_per_pe = '0;
        cfg_namespace    = '0;
        step();
        step();
        ARESETN = 1'b1;
    endtask

    task automatic start_load(input logic [15:0] words, input logic [1:0] ns);
        START            = 1'b1;
        cfg_words_per_pe = words;
        cfg_namespace    = ns;
        step();
        START = 1'b0;
    endtask

    initial begin
        // reset state
        do_reset();
        check("rst_ready", s_ready, 0);
        check("rst_data", pe_data, 0);
        check("rst_ctrl", pe_ctrl, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);

        // basic load: words=2, ns=1, continuous valid, EOC already high
        pe_eoc = 4'hF;
        start_load(16'd2, 2'd1);
        check("t1_busy", busy, 1);
        check("t1_ready0", s_ready, 1);
        s_valid = 1'b1;
        s_data  = 16'h10;
        for (int i = 0; i < 8; i++) begin
            step();
            check("t1_ctrl", pe_ctrl, (i % 4) * 8 + 5);
            check("t1_data", pe_data, 16'h10 + i);
            check("t1_ready", s_ready, (i < 7) ? 1 : 0);
            check("t1_done_early", done, 0);
            s_data = 16'h11 + i;
        end
        s_valid = 1'b0;
        step();
        check("t1_done", done, 1);
        check("t1_ctrl_idle", pe_ctrl, 3 * 8 + 1);
        step();
        check("t1_done_off", done, 0);
        check("t1_busy_off", busy, 0);

        // backpressure gaps, with a START inside LOAD that must be ignored
        do_reset();
        pe_eoc = 4'hF;
        start_load(16'd2, 2'd2);
        for (int b = 0; b < 8; b++) begin
            s_valid = 1'b1;
            s_data  = 16'h20 + b;
            step();
            check("t2_ctrl", pe_ctrl, (b % 4) * 8 + 6);
            check("t2_data", pe_data, 16'h20 + b);
            check("t2_ready", s_ready, (b < 7) ? 1 : 0);
            s_valid = 1'b0;
            if (b == 3) begin
                START            = 1'b1;
                cfg_words_per_pe = 16'd0;
                cfg_namespace    = 2'd0;
            end
            step();
            START = 1'b0;
            check("t2_gap_ctrl", pe_ctrl, (b % 4) * 8 + 2);
            check("t2_gap_done", done, (b == 7) ? 1 : 0);
        end
        step();
        check("t2_busy_off", busy, 0);

        // staggered EOC: PE2 pulses during LOAD, others later
        do_reset();
        start_load(16'd1, 2'd3);
        s_valid = 1'b1;
        pe_eoc  = 4'h4;
        for (int i = 0; i < 4; i++) begin
            s_data = 16'h30 + i;
            step();
            pe_eoc = 4'h0;
            check("t3_ctrl", pe_ctrl, i * 8 + 7);
        end
        s_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t3_wait_done", done, 0);
            check("t3_wait_busy", busy, 1);
        end
        pe_eoc = 4'hB;
        step();
        pe_eoc = 4'h0;
        check("t3_capture_done", done, 0);
        step();
        check("t3_done", done, 1);
        step();
        check("t3_idle", busy, 0);

        // zero words
        do_reset();
        start_load(16'd0, 2'd1);
        check("t4_busy1", busy, 1);
        check("t4_ready1", s_ready, 0);
        check("t4_done1", done, 0);
        step();
        check("t4_busy2", busy, 0);
        check("t4_done2", done, 1);
        check("t4_ready2", s_ready, 0);
        step();
        check("t4_done3", done, 0);

        // reset mid-load, then restart at pe_id 0
        do_reset();
        pe_eoc = 4'hF;
        start_load(16'd2, 2'd1);
        s_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            s_data = 16'h40 + i;
            step();
        end
        check("t5_pre_ctrl", pe_ctrl, 2 * 8 + 5);
        ARESETN = 1'b0;
        s_valid = 1'b0;
        step();
        check("t5_ctrl", pe_ctrl, 0);
        check("t5_data", pe_data, 0);
        check("t5_busy", busy, 0);
        check("t5_ready", s_ready, 0);
        ARESETN = 1'b1;
        start_load(16'd1, 2'd2);
        s_valid = 1'b1;
        s_data  = 16'h50;
        step();
        s_valid = 1'b0;
        check("t5_restart_ctrl", pe_ctrl, 6);
        check("t5_restart_data", pe_data, 16'h50);

`ifdef PE_LOAD_TIMEOUT_EN
        // watchdog: PE3 never reports
        do_reset();
        pe_eoc = 4'h7;
        start_load(16'd1, 2'd0);
        s_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s_data = 16'h60 + i;
            step();
        end
        s_valid = 1'b0;
        for (int i = 0; i < 15; i++) step();
        check("t6_done_early", done, 0);
        check("t6_error_early", error, 0);
        step();
        check("t6_done", done, 1);
        check("t6_error", error, 1);
        step();
        check("t6_error_sticky", error, 1);
        check("t6_idle", busy, 0);
        pe_eoc = 4'hF;
        start_load(16'd1, 2'd0);
        check("t6_error_clr", error, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
